pin_update_ctrl: RTL and testbench

//  Multi-slot PIN update controller for the doorlock datapath. Receives a candidate PIN from the keypad

---
 rtl/pin_update_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_pin_update_ctrl.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pin_update_ctrl.sv
// PIN update controller: takes a PIN entered twice, validates it and writes it into one of
// NUM_SLOTS PIN registers (slot 0 = master). Abort on enable low, timeout in every wait state.
module pin_update_ctrl #(
    parameter int NUM_DIGITS  = 4,
    parameter int DIGIT_W     = 4,
    parameter int NUM_SLOTS   = 4,
    parameter int TIMEOUT_CYC = 5000,
    parameter logic [NUM_DIGITS*DIGIT_W-1:0] DEFAULT_MASTER = 'h1234
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   enable,
    input  logic [$clog2(NUM_SLOTS)-1:0]           slot_sel,
    input  logic                                   pin_valid,
    input  logic [NUM_DIGITS*DIGIT_W-1:0]          pin_digits,
    output logic [NUM_SLOTS*NUM_DIGITS*DIGIT_W-1:0] pins_out,
    output logic [NUM_SLOTS-1:0]                   slot_valid,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   fail,
    output logic [1:0]                             fail_code
);

    localparam int PIN_W = NUM_DIGITS * DIGIT_W;
    localparam int SEL_W = $clog2(NUM_SLOTS);
    localparam int TMR_W = $clog2(TIMEOUT_CYC) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_FIRST,
        S_WAIT_RELEASE,
        S_WAIT_CONFIRM,
        S_CHECK,
        S_COMMIT,
        S_DONE,
        S_FAIL
    } state_t;

    state_t           state;
    logic [PIN_W-1:0] slots [NUM_SLOTS];
    logic [PIN_W-1:0] first_pin;
    logic [PIN_W-1:0] second_pin;
    logic [SEL_W-1:0] slot_q;
    logic [TMR_W-1:0] timer;

    logic digit_bad;
    logic is_dup;
    logic sel_bad;
    logic timed_out;
    logic in_session;

    always_comb begin
        digit_bad = 1'b0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (first_pin[d*DIGIT_W +: DIGIT_W] > DIGIT_W'(9)) begin
                digit_bad = 1'b1;
            end
        end
    end

    // The target slot is excluded so re-programming a slot with its own PIN is allowed
    always_comb begin
        is_dup = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (SEL_W'(i) != slot_q && slot_valid[i] && slots[i] == first_pin) begin
                is_dup = 1'b1;
            end
        end
    end

    assign sel_bad    = {1'b0, slot_sel} >= (SEL_W+1)'(NUM_SLOTS);
    assign timed_out  = (timer == TMR_W'(TIMEOUT_CYC - 1));
    assign in_session = (state != S_IDLE) && (state != S_DONE) && (state != S_FAIL);

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_pins
        assign pins_out[g*PIN_W +: PIN_W] = slots[g];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slots[i] <= (i == 0) ? DEFAULT_MASTER : '0;
            end
            slot_valid <= {{(NUM_SLOTS-1){1'b0}}, 1'b1};
            first_pin  <= '0;
            second_pin <= '0;
            slot_q     <= '0;
            timer      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            fail       <= 1'b0;
            fail_code  <= 2'd0;
        end else if (!enable && in_session) begin
            state <= S_IDLE;
            busy  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (enable) begin
                        slot_q <= slot_sel;
                        timer  <= '0;
                        if (sel_bad) begin
                            fail_code <= 2'd1;
                            fail      <= 1'b1;
                            state     <= S_FAIL;
                        end else begin
                            busy  <= 1'b1;
                            state <= S_WAIT_FIRST;
                        end
                    end
                end
                S_WAIT_FIRST: begin
                    if (pin_valid) begin
                        first_pin <= pin_digits;
                        timer     <= '0;
                        state     <= S_WAIT_RELEASE;
                    end else if (timed_out) begin
                        fail_code <= 2'd3;
                        fail      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_FAIL;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                // A held keypad level must drop before the confirmation entry is accepted
                S_WAIT_RELEASE: begin
                    if (!pin_valid) begin
                        timer <= '0;
                        state <= S_WAIT_CONFIRM;
                    end else if (timed_out) begin
                        fail_code <= 2'd3;
                        fail      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_FAIL;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_WAIT_CONFIRM: begin
                    if (pin_valid) begin
                        second_pin <= pin_digits;
                        timer      <= '0;
                        state      <= S_CHECK;
                    end else if (timed_out) begin
                        fail_code <= 2'd3;
                        fail      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_FAIL;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_CHECK: begin
                    if (digit_bad) begin
                        fail_code <= 2'd1;
                        fail      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_FAIL;
                    end else if (first_pin != second_pin) begin
                        fail_code <= 2'd0;
                        fail      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_FAIL;
                    end else if (is_dup) begin
                        fail_code <= 2'd2;
                        fail      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_FAIL;
                    end else begin
                        state <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    for (int i = 0; i < NUM_SLOTS; i++) begin
                        if (SEL_W'(i) == slot_q) begin
                            slots[i]      <= first_pin;
                            slot_valid[i] <= 1'b1;
                        end
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_DONE;
                end
                S_DONE, S_FAIL: begin
                    if (!enable) begin
                        done  <= 1'b0;
                        fail  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pin_update_ctrl.sv
// Randomised scoreboard bench for pin_update_ctrl: a slot-array reference model predicts each
// session outcome and the cycle it appears; a monitor pops predictions when done/fail rises.
module tb_pin_update_ctrl;

    localparam int TMO = 5000;

    typedef struct {
        bit          is_done;
        logic [1:0]  code;
        int          cyc;
        logic [63:0] pins;
        logic [3:0]  valid;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [1:0]  slot_sel;
    logic        pin_valid;
    logic [15:0] pin_digits;
    logic [63:0] pins_out;
    logic [3:0]  slot_valid;
    logic        busy, done, fail;
    logic [1:0]  fail_code;

    logic        enable6;
    logic [2:0]  slot_sel6;
    logic        pin_valid6;
    logic [23:0] pin_digits6;
    logic [143:0] pins_out6;
    logic [5:0]  slot_valid6;
    logic        busy6, done6, fail6;
    logic [1:0]  fail_code6;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    exp_t exp_q[$];

    logic [15:0] model_slots [4];
    logic [3:0]  model_valid;
    logic [1:0]  model_code;

    pin_update_ctrl u_dut (
        .clk(clk), .rst(rst), .enable(enable), .slot_sel(slot_sel),
        .pin_valid(pin_valid), .pin_digits(pin_digits), .pins_out(pins_out),
        .slot_valid(slot_valid), .busy(busy), .done(done), .fail(fail),
        .fail_code(fail_code)
    );

    pin_update_ctrl #(.NUM_DIGITS(6), .NUM_SLOTS(6), .TIMEOUT_CYC(64)) u_dut6 (
        .clk(clk), .rst(rst), .enable(enable6), .slot_sel(slot_sel6),
        .pin_valid(pin_valid6), .pin_digits(pin_digits6), .pins_out(pins_out6),
        .slot_valid(slot_valid6), .busy(busy6), .done(done6), .fail(fail6),
        .fail_code(fail_code6)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [63:0] model_vec();
        logic [63:0] v;
        for (int s = 0; s < 4; s++) v[s*16 +: 16] = model_slots[s];
        return v;
    endfunction

    function automatic void model_reset();
        model_slots[0] = 16'h1234;
        for (int s = 1; s < 4; s++) model_slots[s] = 16'h0000;
        model_valid = 4'b0001;
        model_code  = 2'd0;
    endfunction

    function automatic bit legal(input logic [15:0] p);
        int v = int'(p);
        for (int d = 0; d < 4; d++) begin
            if ((v / (16 ** d)) % 16 > 9) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [15:0] rand_legal();
        int v = 0;
        for (int d = 0; d < 4; d++) v += $urandom_range(0, 9) * (16 ** d);
        return 16'(v);
    endfunction

    // c is the clock edge at which the confirmation entry is sampled
    function automatic exp_t resolve(input int slot, input logic [15:0] p1, input logic [15:0] p2, input int c);
        exp_t e;
        bit ok = 1'b1;
        e.code = 2'd0;
        if (!legal(p1)) begin
            e.code = 2'd1;
            ok = 1'b0;
        end else if (p1 != p2) begin
            e.code = 2'd0;
            ok = 1'b0;
        end else begin
            for (int s = 0; s < 4; s++) begin
                if (s != slot && model_valid[s] && model_slots[s] == p1) begin
                    e.code = 2'd2;
                    ok = 1'b0;
                end
            end
        end
        if (ok) begin
            model_slots[slot] = p1;
            model_valid[slot] = 1'b1;
            e.is_done = 1'b1;
            e.code = model_code;
            e.cyc = c + 2;
        end else begin
            model_code = e.code;
            e.is_done = 1'b0;
            e.cyc = c + 1;
        end
        e.pins  = model_vec();
        e.valid = model_valid;
        return e;
    endfunction

    initial begin
        exp_t e;
        bit done_q = 1'b0;
        bit fail_q = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst && ((done && !done_q) || (fail && !fail_q))) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected outcome", {done, fail}, 2'b00);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("outcome", {done, fail}, e.is_done ? 2'b10 : 2'b01);
                    if (!e.is_done) checkOutput("fail_code", fail_code, e.code);
                    checkOutput("outcome cycle", cyc, e.cyc);
                    checkOutput("pins_out", pins_out, e.pins);
                    checkOutput("slot_valid", slot_valid, e.valid);
                end
            end
            done_q = done;
            fail_q = fail;
        end
    end

    task automatic finishSession();
        int n = 0;
        while (!(done || fail) && n < 12) begin
            step(1);
            n++;
        end
        if (!(done || fail)) checkOutput("response timeout", 0, 1);
        enable = 1'b0;
        pin_valid = 1'b0;
        step(1);
        checkOutput("done cleared", done, 0);
        checkOutput("fail cleared", fail, 0);
        checkOutput("busy idle", busy, 0);
        checkOutput("fail_code hold", fail_code, model_code);
        step(1);
    endtask

    task automatic applyStimulus(input int slot, input logic [15:0] p1, input logic [15:0] p2,
                                 input bit coincide, input bit abort_s);
        slot_sel = 2'(slot);
        enable   = 1'b1;
        if (coincide) begin
            pin_valid  = 1'b1;
            pin_digits = p1;
            step(1);
        end else begin
            step(1 + $urandom_range(0, 2));
            pin_valid  = 1'b1;
            pin_digits = p1;
        end
        step($urandom_range(1, 3));
        pin_valid  = 1'b0;
        pin_digits = 16'($urandom);
        step($urandom_range(1, 3));
        if (abort_s) begin
            enable = 1'b0;
            step(1);
            checkOutput("abort busy", busy, 0);
            checkOutput("abort done", done, 0);
            checkOutput("abort fail", fail, 0);
            checkOutput("abort pins", pins_out, model_vec());
            checkOutput("abort valid", slot_valid, model_valid);
            step(1);
            return;
        end
        pin_valid  = 1'b1;
        pin_digits = p2;
        exp_q.push_back(resolve(slot, p1, p2, cyc + 1));
        step($urandom_range(1, 2));
        pin_valid  = 1'b0;
        pin_digits = 16'($urandom);
        finishSession();
    endtask

    task automatic timeoutSession(input bit held);
        exp_t e;
        int n = 0;
        slot_sel   = 2'd1;
        enable     = 1'b1;
        pin_valid  = held;
        pin_digits = rand_legal();
        model_code = 2'd3;
        e.is_done = 1'b0;
        e.code    = 2'd3;
        e.cyc     = cyc + (held ? 2 : 1) + TMO;
        e.pins    = model_vec();
        e.valid   = model_valid;
        exp_q.push_back(e);
        while (!fail && n < TMO + 20) begin
            step(1);
            n++;
        end
        if (!fail) checkOutput("timeout never fired", 0, 1);
        finishSession();
    endtask

    initial begin
        logic [15:0] p1, p2;
        int slot, r, n;
        rst = 1'b0;
        enable = 1'b0;
        slot_sel = 2'd0;
        pin_valid = 1'b0;
        pin_digits = 16'h0;
        enable6 = 1'b0;
        slot_sel6 = 3'd0;
        pin_valid6 = 1'b0;
        pin_digits6 = 24'h0;
        model_reset();

        step(3);
        checkOutput("reset pins", pins_out, 64'h0000_0000_0000_1234);
        checkOutput("reset valid", slot_valid, 4'b0001);
        checkOutput("reset flags", {busy, done, fail, fail_code}, 5'b0);
        rst = 1'b1;
        step(1);

        $display("[TB] directed sessions");
        applyStimulus(2, 16'h5678, 16'h5678, 1'b0, 1'b0);
        applyStimulus(1, 16'h5678, 16'h5679, 1'b0, 1'b0);
        applyStimulus(1, 16'h12A4, 16'h12A4, 1'b0, 1'b0);
        applyStimulus(1, 16'h1234, 16'h1234, 1'b0, 1'b0);
        applyStimulus(0, 16'h1234, 16'h1234, 1'b1, 1'b0);
        applyStimulus(1, 16'h5555, 16'h5555, 1'b0, 1'b1);

        $display("[TB] timeout sessions");
        timeoutSession(1'b1);
        timeoutSession(1'b0);

        $display("[TB] reset during commit");
        slot_sel = 2'd3;
        enable = 1'b1;
        step(1);
        pin_valid = 1'b1;
        pin_digits = 16'h4321;
        step(1);
        pin_valid = 1'b0;
        step(1);
        pin_valid = 1'b1;
        step(2);
        checkOutput("commit busy", busy, 1);
        rst = 1'b0;
        #1;
        checkOutput("rst pins", pins_out, 64'h0000_0000_0000_1234);
        checkOutput("rst valid", slot_valid, 4'b0001);
        checkOutput("rst busy", {busy, done}, 2'b00);
        pin_valid = 1'b0;
        enable = 1'b0;
        model_reset();
        step(2);
        rst = 1'b1;
        step(1);

        $display("[TB] random sessions");
        for (int k = 0; k < 40; k++) begin
            slot = $urandom_range(0, 3);
            r = $urandom_range(0, 9);
            p1 = rand_legal();
            if (r == 0) p1 = 16'($urandom);
            if (r == 1 || r == 2) begin
                n = $urandom_range(0, 3);
                if (model_valid[n]) p1 = model_slots[n];
            end
            p2 = ($urandom_range(0, 4) == 0) ? (p1 ^ 16'(1 << $urandom_range(0, 15))) : p1;
            applyStimulus(slot, p1, p2, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
        end

        $display("[TB] wide instance");
        enable6 = 1'b1;
        slot_sel6 = 3'd5;
        step(1);
        pin_valid6 = 1'b1;
        pin_digits6 = 24'h987654;
        step(1);
        pin_valid6 = 1'b0;
        step(1);
        pin_valid6 = 1'b1;
        step(1);
        pin_valid6 = 1'b0;
        n = 0;
        while (!done6 && n < 10) begin
            step(1);
            n++;
        end
        checkOutput("wide done", done6, 1);
        checkOutput("wide slot5", pins_out6[5*24 +: 24], 24'h987654);
        checkOutput("wide slot0", pins_out6[23:0], 24'h001234);
        checkOutput("wide valid", slot_valid6, 6'b100001);
        enable6 = 1'b0;
        step(1);
        slot_sel6 = 3'd6;
        enable6 = 1'b1;
        step(1);
        checkOutput("bad slot fail", {fail6, busy6}, 2'b10);
        checkOutput("bad slot code", fail_code6, 2'd1);
        enable6 = 1'b0;
        step(1);

        step(5);
        checkOutput("scoreboard drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
